// File: rtl/neuron_pkg.sv
// neuron_pkg
// Shared definitions for the multi-input neuron:
//   - clog2 helper, used to size the accumulator and the MAC index
//   - default width constants for the neuron parameters
//   - FSM state encoding (IDLE / MAC / DONE)
package neuron_pkg;

    // Ceiling log2. Returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    localparam int NEURON_NUM_INPUTS_DEF = 4;
    localparam int NEURON_INPUT_W_DEF    = 9;
    localparam int NEURON_WEIGHT_W_DEF   = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } neuron_state_e;

endpackage

// File: rtl/neuron_trace.sv
// neuron_trace
// One synaptic channel's event trace. An event loads the maximum value,
// a decay tick decrements by one (saturating at zero), otherwise the
// trace holds. An event wins over a coincident decay tick.
// Ports:
//   i_clk        clock
//   i_rst        asynchronous active-high reset (trace cleared to 0)
//   i_event      event pulse for this channel
//   i_decay_tick global decay strobe
//   o_trace      current trace value
module neuron_trace #(
    parameter int p_width = 9
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_event,
    input  logic               i_decay_tick,
    output logic [p_width-1:0] o_trace
);

    localparam logic [p_width-1:0] TRACE_MAX = {p_width{1'b1}};

    logic [p_width-1:0] trace_q;
    logic [p_width-1:0] trace_d;

    always_comb begin
        trace_d = trace_q;
        if (i_event) begin
            trace_d = TRACE_MAX;
        end else if (i_decay_tick && (trace_q != '0)) begin
            trace_d = trace_q - p_width'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            trace_q <= '0;
        end else begin
            trace_q <= trace_d;
        end
    end

    assign o_trace = trace_q;

endmodule

// File: rtl/neuron_nin.sv
// neuron_nin
// Multi-input neuron. Each of p_num_inputs channels keeps a decaying
// event trace. On i_eval the live traces are snapshotted and a single
// multiply-accumulate walks the channels, one per cycle, forming
// sum(trace_k * weight_k). The sum is compared with the threshold
// (strictly greater fires) and reported with a one-cycle o_done.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_event        per-channel event pulses (bit k -> channel k)
//   i_decay_tick   decay strobe for all traces
//   i_weights      packed unsigned weights, channel k at [k*W +: W]
//   i_threshold    firing threshold
//   i_eval         evaluation request (ignored while busy)
//   i_spike        level-capture strobe
//   o_busy         evaluation in progress (MAC phase)
//   o_done         one-cycle completion pulse
//   o_fire         valid with o_done: sum > threshold
//   o_neuron_out   sum if fired, else 0; held until next o_done
//   o_lv           captured level for the training logic
//   o_tr           live packed traces
module neuron_nin
    import neuron_pkg::*;
#(
    parameter int p_num_inputs   = NEURON_NUM_INPUTS_DEF,
    parameter int p_input_width  = NEURON_INPUT_W_DEF,
    parameter int p_weight_width = NEURON_WEIGHT_W_DEF,
    parameter int p_acc_width    = p_input_width + p_weight_width + clog2(p_num_inputs)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [p_num_inputs-1:0]                i_event,
    input  logic                                   i_decay_tick,
    input  logic [p_num_inputs*p_weight_width-1:0] i_weights,
    input  logic [p_acc_width-1:0]                 i_threshold,
    input  logic                                   i_eval,
    input  logic                                   i_spike,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_fire,
    output logic [p_acc_width-1:0]                 o_neuron_out,
    output logic [p_acc_width-1:0]                 o_lv,
    output logic [p_num_inputs*p_input_width-1:0]  o_tr
);

    localparam int IDX_W  = (clog2(p_num_inputs) < 1) ? 1 : clog2(p_num_inputs);
    localparam int PROD_W = p_input_width + p_weight_width;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(p_num_inputs - 1);

    // Per-channel traces
    logic [p_input_width-1:0] tr [p_num_inputs];

    for (genvar k = 0; k < p_num_inputs; k++) begin : g_trace
        neuron_trace #(
            .p_width (p_input_width)
        ) u_trace (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_event      (i_event[k]),
            .i_decay_tick (i_decay_tick),
            .o_trace      (tr[k])
        );
        assign o_tr[k*p_input_width +: p_input_width] = tr[k];
    end

    // Control and datapath state
    neuron_state_e            state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [p_acc_width-1:0]   acc_q, acc_d;
    logic [p_input_width-1:0] snap_q [p_num_inputs];
    logic [p_input_width-1:0] snap_d [p_num_inputs];
    logic                     done_q, done_d;
    logic                     fire_q, fire_d;
    logic [p_acc_width-1:0]   nout_q, nout_d;
    logic [p_acc_width-1:0]   lv_q, lv_d;

    // MAC operands: snapshot entry and the live weight at the current index
    logic [p_input_width-1:0]  snap_sel;
    logic [p_weight_width-1:0] w_sel;
    logic [PROD_W-1:0]         prod;
    logic [p_acc_width-1:0]    acc_sum;

    always_comb begin
        snap_sel = snap_q[idx_q];
        w_sel    = i_weights[int'(idx_q)*p_weight_width +: p_weight_width];
        prod     = PROD_W'(snap_sel) * PROD_W'(w_sel);
        acc_sum  = acc_q + p_acc_width'(prod);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        fire_d  = fire_q;
        nout_d  = nout_q;
        lv_d    = lv_q;

        case (state_q)
            ST_IDLE: begin
                if (i_eval) begin
                    snap_d  = tr;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_sum;
                if (idx_q == IDX_LAST) begin
                    // Result flops are loaded on the final MAC edge so they
                    // are already valid during the DONE cycle.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fire_d  = (acc_sum > i_threshold);
                    nout_d  = (acc_sum > i_threshold) ? acc_sum : '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // nout_q equals the sum of the last evaluation whenever that
        // evaluation fired, so it is safe to capture even mid-MAC when
        // acc_q holds a partial sum.
        if (i_spike && fire_q) begin
            lv_d = nout_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            fire_q  <= 1'b0;
            nout_q  <= '0;
            lv_q    <= '0;
            for (int k = 0; k < p_num_inputs; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            fire_q  <= fire_d;
            nout_q  <= nout_d;
            lv_q    <= lv_d;
            for (int k = 0; k < p_num_inputs; k++) begin
                snap_q[k] <= snap_d[k];
            end
        end
    end

    assign o_busy       = (state_q == ST_MAC);
    assign o_done       = done_q;
    assign o_fire       = done_q & fire_q;
    assign o_neuron_out = nout_q;
    assign o_lv         = lv_q;

endmodule

// File: doc/neuron_nin.md
Name: neuron_nin

Overview:
- Parametrised successor to the two-input neuron: p_num_inputs synaptic channels, each with a decaying event trace and a weight.
- A single time-multiplexed multiply-accumulate evaluates the weighted sum on request, compares it with a threshold and reports fire or no-fire.
- A level register captures the last sum on i_spike, for the training logic.
- Sits between the event front-end and the layer's winner-select and training logic.

Parameters:
- p_num_inputs, 4: number of synaptic channels (2..64).
- p_input_width, 9: trace width; trace maximum is 2^p_input_width-1.
- p_weight_width, 9: unsigned weight width.
- p_acc_width, p_input_width+p_weight_width+clog2(p_num_inputs): sum, level and threshold width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_event  in  p_num_inputs  per-channel input event pulse; bit k drives channel k.
- i_decay_tick  in  1  decay strobe; every trace decrements by 1 on this strobe.
- i_weights  in  p_num_inputs*p_weight_width  packed weights; channel k is at [k*p_weight_width +: p_weight_width].
- i_threshold  in  p_acc_width  firing threshold.
- i_eval  in  1  evaluation request pulse.
- i_spike  in  1  level-capture strobe.
- o_busy  out  1  high while an evaluation is in progress.
- o_done  out  1  one-cycle pulse when an evaluation completes.
- o_fire  out  1  valid with o_done: sum > threshold.
- o_neuron_out  out  p_acc_width  sum if fired, else 0; held until the next o_done.
- o_lv  out  p_acc_width  captured level.
- o_tr  out  p_num_inputs*p_input_width  live packed traces.

Behaviour:
- Reset: all traces, snapshot, accumulator, o_lv and o_neuron_out are 0; o_busy, o_done and o_fire are 0; FSM is in IDLE.
- Trace k, registered, in priority order:
  - i_event[k] loads the maximum.
  - else i_decay_tick decrements by 1, saturating at 0.
  - else holds.
- Trace priority rules:
  - An event in the same cycle as a decay tick yields the maximum.
  - Traces update in every FSM state.
- FSM states are IDLE, MAC and DONE.
- IDLE:
  - i_eval=1 copies all live traces into the snapshot, clears the accumulator and index, raises o_busy and moves to MAC.
  - i_eval while busy is ignored, not queued.
- MAC:
  - Each cycle: acc += snap[idx]*weight[idx]; idx increments.
  - Weights are sampled live and must be stable while o_busy is high.
  - After idx = p_num_inputs-1, go to DONE.
- DONE, one cycle:
  - o_done=1; o_fire = (acc > i_threshold), strictly greater.
  - o_neuron_out = o_fire ? acc : 0.
  - o_busy drops; return to IDLE.
- Latency: i_eval at cycle T gives o_done at cycle T+p_num_inputs+1.
- Throughput: a new i_eval is accepted in the cycle after o_done.
- Events arriving during MAC do not affect the running sum because it uses the snapshot.
- Arithmetic:
  - Product width p_input_width+p_weight_width, zero-extended to p_acc_width.
  - Accumulator cannot overflow by construction.
- o_lv:
  - On i_spike=1, o_lv takes acc if o_fire was asserted at the last o_done, else it holds.
  - i_spike coincident with o_done captures the new acc.
- Reset asserted mid-MAC: immediate abort to IDLE; all state cleared; no o_done is produced.

Decomposition:
- Package neuron_pkg holds a clog2 function, default width constants and FSM state encodings (IDLE/MAC/DONE).
- Sub-module neuron_trace: one channel's saturating load/decay trace, generated p_num_inputs times.
- The FSM, snapshot and MAC live in the top level.

Test Plan:
- Defaults, weights all 1, events on all channels, then i_eval → o_done after 5 cycles, acc=4*511=2044; threshold 2000 gives o_fire=1 and o_neuron_out=2044.
- Same stimulus with threshold 2044 → o_fire=0, o_neuron_out=0 (strict compare).
- Event ch0, then 10 decay ticks, weight0=3, others 0 → trace0=501, sum=1503; event coincident with a tick → trace=511.
- i_eval, then an event on ch2 during MAC plus a second i_eval → sum uses the snapshot; second request ignored; exactly one o_done.
- Fire, then i_spike → o_lv=sum; later a no-fire evaluation followed by i_spike → o_lv unchanged.
- i_rst asserted mid-MAC → o_busy=0 and all outputs 0 immediately; no o_done follows; next i_eval works normally.
